// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO registers.
// Latency: result and done land WIDTH+1 edges after the accepting edge; busy is high for WIDTH+1 cycles.
// Backpressure: start is ignored while busy=1, with no queueing; wr_hi/wr_lo are also ignored while busy=1.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start, op, X, Y     issue request, operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU) and operands rs/rt
//   wr_hi, wr_lo        MTHI/MTLO write enables, using wr_data
//   busy, done          operation in flight / one-cycle completion pulse
//   div_by_zero         qualifies done; the divide had Y=0
//   hi, lo              architectural HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             is_div_q;
    logic             neg_res_q;    // product/quotient must be negated
    logic             neg_rem_q;    // remainder must be negated
    logic             dbz_q;
    logic [WIDTH-1:0] x_raw_q;      // unmodified dividend, returned on divide by zero
    logic [WIDTH-1:0] b_q;          // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] acc_hi_q;     // product upper half / partial remainder
    logic [WIDTH-1:0] acc_lo_q;     // multiplier bits / dividend bits becoming quotient
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q, dbz_out_q;

    // Issue-time operand conditioning. Negating the most negative value wraps back
    // to itself, which read as unsigned is exactly the required magnitude.
    logic             x_neg, y_neg;
    logic [WIDTH-1:0] x_mag, y_mag;

    always_comb begin
        x_neg = X[WIDTH-1] & ~op[0];
        y_neg = Y[WIDTH-1] & ~op[0];
        x_mag = x_neg ? (~X + 1'b1) : X;
        y_mag = y_neg ? (~Y + 1'b1) : Y;
    end

    // One iteration of either algorithm, computed from the current accumulator.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] acc_hi_d, acc_lo_d;

    always_comb begin
        // Shift-add: add the multiplicand when the current multiplier LSB is set,
        // then shift the whole {carry, upper, lower} right by one.
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        // Restoring divide: bring in the next dividend bit and try a subtract.
        rem_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, b_q};
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        if (is_div_q) begin
            acc_hi_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    // Final sign correction of the unsigned magnitude results.
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = neg_res_q ? (~prod + 1'b1) : prod;
        quo_fix  = neg_res_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
        rem_fix  = neg_rem_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            x_raw_q   <= '0;
            b_q       <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;

            // MTHI/MTLO only while idle; a result written in FIX overrides these.
            if (!busy_q) begin
                if (wr_hi) hi_q <= wr_data;
                if (wr_lo) lo_q <= wr_data;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_div_q  <= op[1];
                        neg_res_q <= x_neg ^ y_neg;
                        neg_rem_q <= x_neg;
                        dbz_q     <= op[1] & (Y == '0);
                        x_raw_q   <= X;
                        cnt_q     <= '0;
                        acc_hi_q  <= '0;
                        if (op[1]) begin
                            b_q      <= y_mag;
                            acc_lo_q <= x_mag;
                        end else begin
                            b_q      <= x_mag;
                            acc_lo_q <= y_mag;
                        end
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) state_q <= FIX;
                end
                FIX: begin
                    if (dbz_q) begin
                        hi_q <= x_raw_q;
                        lo_q <= '1;
                    end else if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    dbz_out_q <= dbz_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_out_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors, corner sequences and randomized ops against an arithmetic model.
// Latency: each operation is expected to complete 33 edges after acceptance.
// Backpressure: checks that start/wr while busy are ignored and that start in the done cycle is accepted.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] X = '0, Y = '0, wr_data = '0;
    logic         wr_hi = 1'b0, wr_lo = 1'b0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .X(X), .Y(Y),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
    // the remainder follows the dividend sign, matching the architectural rules.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint unsigned ux = 64'(x);
        longint unsigned uy = 64'(y);
        logic [63:0]     p;
        ed = 1'b0;
        eh = '0;
        el = '0;
        p  = '0;
        case (o)
            MULT:  begin p = 64'(sx * sy); eh = p[63:32]; el = p[31:0]; end
            MULTU: begin p = ux * uy;      eh = p[63:32]; el = p[31:0]; end
            default: begin
                if (y == '0) begin
                    ed = 1'b1; eh = x; el = '1;
                end else if (o == DIV) begin
                    el = 32'(sx / sy); eh = 32'(sx % sy);
                end else begin
                    el = 32'(ux / uy); eh = 32'(ux % uy);
                end
            end
        endcase
    endfunction

    // Issues one op and waits for done. Inputs change right after each edge, so
    // the accepting edge is the first posedge after start is raised. If inject_at
    // is nonzero, start+wr_hi are pulsed so they are sampled at that edge.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int inject_at,
                          output logic [W-1:0] r_hi, output logic [W-1:0] r_lo, output logic r_dbz);
        logic [W-1:0] hi0, lo0;
        int busy_n, lat;
        bit held;
        hi0 = hi; lo0 = lo;
        op = o; X = x; Y = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        X = $urandom; Y = $urandom; op = 2'($urandom);
        chk({tag, " busy_after_accept"}, 64'(busy), 64'(1));
        chk({tag, " done_low_after_accept"}, 64'(done), 64'(0));
        busy_n = busy ? 1 : 0;
        lat = 0;
        held = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k == inject_at) begin
                start = 1'b1; wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
                X = 32'h0000_0003; Y = 32'h0000_0005; op = MULTU;
            end
            @(posedge clk); #1;
            if (k == inject_at) begin start = 1'b0; wr_hi = 1'b0; end
            if (done) begin lat = k; break; end
            if (busy) busy_n++;
            if (hi !== hi0 || lo !== lo0) held = 1'b0;
        end
        chk({tag, " done_latency"}, 64'(lat), 64'(33));
        chk({tag, " busy_cycles"}, 64'(busy_n), 64'(33));
        chk({tag, " hilo_held"}, 64'(held), 64'(1));
        chk({tag, " busy_low_in_done"}, 64'(busy), 64'(0));
        r_hi = hi; r_lo = lo; r_dbz = div_by_zero;
    endtask

    typedef struct {
        string      name;
        logic [1:0] o;
        logic [W-1:0] x, y, eh, el;
        logic       ed;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [W-1:0] gh, gl, eh, el, x, y;
        logic gd, ed;
        logic [1:0] o;

        vecs[0]  = '{"multu_ffff_x2", MULTU, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        vecs[1]  = '{"mult_m3_x5",    MULT,  32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2]  = '{"mult_min_sq",   MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[3]  = '{"div_m7_2",      DIV,   32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{"divu_100_7",    DIVU,  32'd100,       32'd7,          32'd2,         32'd14,        1'b0};
        vecs[5]  = '{"div_min_m1",    DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[6]  = '{"divu_by_zero",  DIVU,  32'd100,       32'd0,          32'd100,       32'hFFFF_FFFF, 1'b1};
        vecs[7]  = '{"multu_after_dz",MULTU, 32'd3,         32'd3,          32'd0,         32'd9,         1'b0};
        vecs[8]  = '{"div_neg_by_zero",DIV,  32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{"div_7_m2",      DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[10] = '{"multu_max_sq",  MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", 64'(hi), 64'(0));
        chk("reset_lo", 64'(lo), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_dbz", 64'(div_by_zero), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table; consecutive ops start in the previous done cycle.
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].name, vecs[i].o, vecs[i].x, vecs[i].y, 0, gh, gl, gd);
            chk({vecs[i].name, " hi"}, 64'(gh), 64'(vecs[i].eh));
            chk({vecs[i].name, " lo"}, 64'(gl), 64'(vecs[i].el));
            chk({vecs[i].name, " dbz"}, 64'(gd), 64'(vecs[i].ed));
        end

        // Busy interlock: start+wr_hi sampled at edge 10 must be ignored.
        model(MULTU, 32'h1234_5678, 32'd9, eh, el, ed);
        run_op("interlock", MULTU, 32'h1234_5678, 32'd9, 10, gh, gl, gd);
        chk("interlock hi", 64'(gh), 64'(eh));
        chk("interlock lo", 64'(gl), 64'(el));
        @(posedge clk); #1;
        chk("interlock no_second_op", 64'(busy), 64'(0));

        // MTLO after completion leaves HI alone.
        wr_lo = 1'b1; wr_data = 32'h0000_1234;
        @(posedge clk); #1;
        wr_lo = 1'b0;
        chk("mtlo lo", 64'(lo), 64'h1234);
        chk("mtlo hi_unchanged", 64'(hi), 64'(eh));

        // MTHI + MTLO together.
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hCAFE_0001;
        @(posedge clk); #1;
        wr_hi = 1'b0; wr_lo = 1'b0;
        chk("mthilo hi", 64'(hi), 64'hCAFE_0001);
        chk("mthilo lo", 64'(lo), 64'hCAFE_0001);

        // Reset in the middle of a divide.
        op = DIV; X = 32'd100; Y = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset hi", 64'(hi), 64'(0));
        chk("midreset lo", 64'(lo), 64'(0));
        chk("midreset busy", 64'(busy), 64'(0));
        chk("midreset done", 64'(done), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_reset_6x7", MULTU, 32'd6, 32'd7, 0, gh, gl, gd);
        chk("post_reset hi", 64'(gh), 64'(0));
        chk("post_reset lo", 64'(gl), 64'd42);

        // Randomized ops against the model, biased toward boundary operands.
        for (int n = 0; n < 40; n++) begin
            o = 2'($urandom);
            case ($urandom_range(0, 4))
                0: x = 32'h8000_0000;
                1: x = 32'hFFFF_FFFF;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: y = 32'h0;
                1: y = 32'hFFFF_FFFF;
                2: y = 32'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            model(o, x, y, eh, el, ed);
            run_op("rand", o, x, y, 0, gh, gl, gd);
            chk("rand hi", 64'(gh), 64'(eh));
            chk("rand lo", 64'(gl), 64'(el));
            chk("rand dbz", 64'(gd), 64'(ed));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, alongside the combinational ALU.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and holds the architectural HI/LO registers.
- Raises busy so the hazard unit can stall dependent MFHI/MFLO and further mul/div issue.
- HI/LO outputs feed the EX-result mux for MFHI/MFLO; MTHI/MTLO write them directly.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  issue request; sampled only when busy=0
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- X  input  WIDTH  operand rs (multiplicand / dividend)
- Y  input  WIDTH  operand rt (multiplier / divisor)
- wr_hi  input  1  MTHI write enable
- wr_lo  input  1  MTLO write enable
- wr_data  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in flight
- done  output  1  one-cycle completion pulse
- div_by_zero  output  1  valid with done; divide with Y=0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; any in-flight operation is discarded.
- States: IDLE, RUN, FIX.
- Edge 0, IDLE with start=1:
  - latch op and operand magnitudes; signed ops use two's-complement abs, and abs(0x80000000) is unsigned 0x80000000.
  - latch result-sign flags: quotient/product sign = X[31]^Y[31]; remainder sign = X[31].
  - counter=0, busy->1, state->RUN.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. After the WIDTH-th step (edge 32), state->FIX.
- FIX (edge 33):
  - apply sign correction (signed ops only).
  - multiply: hi=upper half, lo=lower half of the 64-bit product.
  - divide: lo=quotient, hi=remainder.
  - done->1, busy->0, state->IDLE.
- Timing:
  - done is high exactly one cycle (edge 33 to edge 34).
  - busy is high for 33 cycles.
  - hi/lo hold their old values until edge 33.
- Divide by zero (DIV/DIVU, Y=0):
  - same latency; lo=all ones, hi=X (original, unsigned).
  - div_by_zero=1 coincident with done, cleared with done.
  - no sign correction.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no exception.
- start while busy=1 is ignored; no queueing.
- start and done in the same cycle: the new operation is accepted at that edge (busy=0 in the done cycle).
- wr_hi/wr_lo:
  - honoured only when busy=0; take effect at the next edge; ignored while busy=1.
  - If wr_hi/wr_lo and start occur in the same IDLE cycle, the write lands at edge 0 and is overwritten by the result at edge 33.
  - wr_hi and wr_lo together write both registers with wr_data.
- Operands X, Y and op may change freely after edge 0; only latched copies are used.

Test Plan:
- MULTU X=0xFFFFFFFF, Y=2 -> done at edge 33, hi=0x00000001, lo=0xFFFFFFFE, busy high 33 cycles, div_by_zero=0.
- MULT X=-3 (0xFFFFFFFD), Y=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV X=-7, Y=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU X=100, Y=7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU X=100, Y=0 -> done at edge 33 with div_by_zero=1, lo=0xFFFFFFFF, hi=100. The next done pulse has div_by_zero=0.
- Busy interlock:
  - start a MULTU; at edge 10 pulse start with new operands plus wr_hi=1 -> both ignored, result is from the first op only.
  - after done, wr_lo=1, wr_data=0x1234 -> lo=0x1234 next edge, hi unchanged.
- Reset mid-operation: drop rst_n at edge 15 of a DIV -> immediately hi=lo=0, busy=0, done=0. After release, a new MULTU 6*7 -> lo=42, hi=0 at edge 33.
